// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter with burst lock for a shared FIFO
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic                    i_fifo_full,
    output logic                    o_fifo_wren,
    output logic [DATA_W-1:0]       o_fifo_wrdata,
    output logic [ID_W-1:0]         o_fifo_wrid,
    output logic                    o_locked
);
    logic [ID_W-1:0]   rr_ptr_rg, owner_rg, rr_gnt, gnt;
    logic [CNT_W-1:0]  cnt_rg;
    logic              lock_rg, rr_hit, lock_hit, xfer, burst_go;
    logic [ID_W:0]     s;
    logic [CNT_W:0]    n;
    logic [DATA_W-1:0] d [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign d[k] = i_req_data[k*DATA_W +: DATA_W];
    end

    // round-robin search from rr_ptr_rg; scanning downward lets the nearest valid index win
    always_comb begin
        rr_hit = 1'b0;
        rr_gnt = '0;
        s      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            s = {1'b0, rr_ptr_rg} + (ID_W+1)'(i);
            s = (s >= (ID_W+1)'(N_REQ)) ? s - (ID_W+1)'(N_REQ) : s;
            if (i_req_valid[s[ID_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_gnt = s[ID_W-1:0];
            end
        end
    end

    // the lock keeps the owner granted while it stays valid; otherwise fall back to the search
    always_comb begin
        lock_hit      = lock_rg && i_req_valid[owner_rg];
        gnt           = lock_hit ? owner_rg : rr_gnt;
        xfer          = rstn && (lock_hit || rr_hit) && !i_fifo_full;
        n             = (lock_rg && gnt == owner_rg) ? {1'b0, cnt_rg} + (CNT_W+1)'(1) : (CNT_W+1)'(1);
        burst_go      = n < (CNT_W+1)'(MAX_BURST);
        o_req_ready   = xfer ? N_REQ'(1) << gnt : '0;
        o_fifo_wren   = xfer;
        o_fifo_wrdata = xfer ? d[gnt] : '0;
        o_fifo_wrid   = xfer ? gnt : '0;
        o_locked      = rstn && lock_rg;
    end

    // advance pointer, owner and burst count on a write; drop the lock when the owner leaves
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_rg <= '0;
            owner_rg  <= '0;
            cnt_rg    <= '0;
            lock_rg   <= 1'b0;
        end else if (xfer) begin
            rr_ptr_rg <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
            owner_rg  <= gnt;
            lock_rg   <= burst_go;
            cnt_rg    <= burst_go ? n[CNT_W-1:0] : '0;
        end else if (lock_rg && !i_req_valid[owner_rg]) begin
            lock_rg <= 1'b0;
            cnt_rg  <= '0;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table, directed and random checks of two arbiter builds (burst 4 and 1)
module tb_fifo_wr_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  valid = '0;
    logic [15:0] data = 16'hDCBA;
    logic        full = 1'b0;

    logic [3:0] rdy4, rdy1, wd4, wd1;
    logic [1:0] id4, id1;
    logic       wren4, wren1, lk4, lk1;

    int compared = 0;
    int mismatched = 0;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(4), .MAX_BURST(4)) u4 (
        .clk(clk), .rstn(rstn), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(rdy4), .i_fifo_full(full), .o_fifo_wren(wren4),
        .o_fifo_wrdata(wd4), .o_fifo_wrid(id4), .o_locked(lk4));

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(4), .MAX_BURST(1)) u1 (
        .clk(clk), .rstn(rstn), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(rdy1), .i_fifo_full(full), .o_fifo_wren(wren1),
        .o_fifo_wrdata(wd1), .o_fifo_wrid(id1), .o_locked(lk1));

    always #5 clk = ~clk;

    // reference model: burst owner, its run length and the next search start, per build
    int mb[2] = '{4, 1};
    int m_ptr[2], m_own[2], m_run[2];
    bit m_lk[2];
    int n_ptr[2], n_own[2], n_run[2];
    bit n_lk[2];
    int x_ready[2], x_data[2], x_id[2];
    bit x_wren[2], x_lk[2];

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic predict(input int k);
        int g, run;
        g = -1;
        if (m_lk[k] && valid[m_own[k]]) g = m_own[k];
        for (int j = 0; j < N; j++)
            if (g < 0 && valid[(m_ptr[k] + j) % N]) g = (m_ptr[k] + j) % N;
        x_wren[k]  = rstn && g >= 0 && !full;
        x_id[k]    = x_wren[k] ? g : 0;
        x_ready[k] = x_wren[k] ? (1 << g) : 0;
        x_data[k]  = x_wren[k] ? int'((data >> (4 * g)) & 16'hF) : 0;
        x_lk[k]    = rstn && m_lk[k];
        n_ptr[k] = m_ptr[k]; n_own[k] = m_own[k]; n_run[k] = m_run[k]; n_lk[k] = m_lk[k];
        if (!rstn) begin
            n_ptr[k] = 0; n_own[k] = 0; n_run[k] = 0; n_lk[k] = 0;
        end else if (x_wren[k]) begin
            run = (m_lk[k] && g == m_own[k]) ? m_run[k] + 1 : 1;
            n_ptr[k] = (g + 1) % N;
            n_own[k] = g;
            n_lk[k]  = run < mb[k];
            n_run[k] = run < mb[k] ? run : 0;
        end else if (m_lk[k] && !valid[m_own[k]]) begin
            n_lk[k] = 0; n_run[k] = 0;
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        predict(0);
        predict(1);
        chk("u4.ready", int'(rdy4), x_ready[0]);
        chk("u4.wren", int'(wren4), int'(x_wren[0]));
        chk("u4.wrdata", int'(wd4), x_data[0]);
        chk("u4.wrid", int'(id4), x_id[0]);
        chk("u4.locked", int'(lk4), int'(x_lk[0]));
        chk("u1.ready", int'(rdy1), x_ready[1]);
        chk("u1.wren", int'(wren1), int'(x_wren[1]));
        chk("u1.wrdata", int'(wd1), x_data[1]);
        chk("u1.wrid", int'(id1), x_id[1]);
        chk("u1.locked", int'(lk1), int'(x_lk[1]));
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = n_ptr[k]; m_own[k] = n_own[k]; m_run[k] = n_run[k]; m_lk[k] = n_lk[k];
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        check_cycle();
        advance();
        rstn = 1'b1;
    endtask

    typedef struct {
        bit         rstn;
        logic [3:0] v;
        bit         full;
        bit         w4;
        int         id4;
        bit         lk4;
        bit         w1;
        int         id1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [3:0] v, input bit f, input bit w4, input int i4,
                       input bit l4, input bit w1, input int i1);
        vec_t e;
        e.rstn = r; e.v = v; e.full = f; e.w4 = w4; e.id4 = i4; e.lk4 = l4; e.w1 = w1; e.id1 = i1;
        tbl.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) add(0, 4'hF, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) add(1, 4'hF, 0, 1, (i / 4) % 4, (i % 4) != 0, 1, i % 4);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 1, 0, 0, 1, 0, 0);
        add(1, 4'hF, 0, 1, 1, 1, 1, 2);
        add(1, 4'hF, 0, 1, 1, 1, 1, 3);
        add(1, 4'hF, 0, 1, 2, 0, 1, 0);

        #1;
        foreach (tbl[i]) begin
            rstn = tbl[i].rstn; valid = tbl[i].v; full = tbl[i].full;
            check_cycle();
            chk($sformatf("tbl%0d.u4.wren", i), int'(wren4), int'(tbl[i].w4));
            chk($sformatf("tbl%0d.u4.wrid", i), int'(id4), tbl[i].id4);
            chk($sformatf("tbl%0d.u4.locked", i), int'(lk4), int'(tbl[i].lk4));
            chk($sformatf("tbl%0d.u1.wren", i), int'(wren1), int'(tbl[i].w1));
            chk($sformatf("tbl%0d.u1.wrid", i), int'(id1), tbl[i].id1);
            chk($sformatf("tbl%0d.u1.locked", i), int'(lk1), 0);
            advance();
        end
        full = 1'b0;

        do_reset();
        valid = 4'b0100;
        check_cycle(); chk("drop.first", int'(id4), 2); advance();
        valid = 4'b1101;
        check_cycle(); chk("drop.second", int'(id4), 2); advance();
        valid = 4'b1001;
        check_cycle(); chk("drop.same_cycle", int'(id4), 3); chk("drop.wren", int'(wren4), 1); advance();
        for (int j = 0; j < 3; j++) begin
            check_cycle(); chk("drop.burst3", int'(id4), 3); advance();
        end
        check_cycle(); chk("drop.then0", int'(id4), 0); chk("drop.unlocked", int'(lk4), 0); advance();

        rstn = 1'b0; valid = 4'hF;
        check_cycle();
        chk("midrst.locked", int'(lk4), 0); chk("midrst.ready", int'(rdy4), 0); chk("midrst.wren", int'(wren4), 0);
        advance();
        rstn = 1'b1; valid = 4'b1110;
        check_cycle(); chk("postrst.u4", int'(id4), 1); chk("postrst.u1", int'(id1), 1); advance();

        do_reset();
        valid = 4'b1001;
        for (int j = 0; j < 4; j++) begin
            check_cycle(); chk("sparse.u1", int'(id1), (j % 2) ? 3 : 0); chk("sparse.u4", int'(id4), 0); advance();
        end

        for (int c = 0; c < 800; c++) begin
            rstn  = $urandom_range(40) != 0;
            valid = 4'($urandom);
            data  = 16'($urandom);
            full  = $urandom_range(3) == 0;
            check_cycle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of a `fifo_bram` instance between `N_REQ` producers. Each producer has a valid/ready handshake. The arbiter steers one producer's data into the FIFO per cycle and tags each write with the producer index. A burst lock keeps one producer granted for up to `MAX_BURST` back-to-back writes, which limits interleaving without starving the other producers.

## Interface
- `N_REQ`, 4: number of requesters; must be ≥2.
- `DATA_W`, 4: data width; must match the FIFO's `DATA_W`.
- `MAX_BURST`, 4: maximum consecutive grants to one requester; must be ≥1. A value of 1 gives pure round-robin.
- `ID_W`, `$clog2(N_REQ)`: derived; requester index width.
- `CNT_W`, `$clog2(MAX_BURST+1)`: derived; burst counter width.

- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `i_req_valid`  in  N_REQ  per-requester valid.
- `i_req_data`  in  N_REQ*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- `o_req_ready`  out  N_REQ  per-requester ready; at most one bit is set (one-hot or zero).
- `i_fifo_full`  in  1  FIFO full flag (`o_full`).
- `o_fifo_wren`  out  1  FIFO write enable (`i_wren`).
- `o_fifo_wrdata`  out  DATA_W  FIFO write data (`i_wrdata`).
- `o_fifo_wrid`  out  ID_W  index of the requester being written; valid when `o_fifo_wren`=1.
- `o_locked`  out  1  burst lock currently held (status).

## Operation
- State registers:
  - `rr_ptr_rg` [ID_W]: highest-priority index for the search.
  - `owner_rg` [ID_W]: current burst owner.
  - `cnt_rg` [CNT_W]: writes completed in the current burst.
  - `lock_rg`: the FSM. LOCK=0 is IDLE, LOCK=1 is BURST.
- Grant selection (combinational):
  - If `lock_rg` is set and `i_req_valid[owner_rg]` is set, the grant is `owner_rg`.
  - Otherwise the grant is the first set `i_req_valid` bit found by searching `rr_ptr_rg`, `rr_ptr_rg`+1, … with wrap modulo N_REQ.
  - If no valid bit is set, there is no grant.
- Transfer condition: a grant exists and `i_fifo_full`=0. On a transfer:
  - `o_req_ready[g]`=1 and `o_fifo_wren`=1.
  - `o_fifo_wrdata` = data of requester g.
  - `o_fifo_wrid` = g.
- When there is no transfer: `o_req_ready`=0, `o_fifo_wren`=0, `o_fifo_wrdata`=0, `o_fifo_wrid`=0.
- Register update on a transfer from g:
  - `rr_ptr_rg` ← (g==N_REQ-1) ? 0 : g+1.
  - `owner_rg` ← g.
  - n = (`lock_rg` && g==`owner_rg`) ? `cnt_rg`+1 : 1.
  - If n < MAX_BURST: `lock_rg` ← 1, `cnt_rg` ← n (IDLE→BURST, or stay in BURST).
  - Otherwise: `lock_rg` ← 0, `cnt_rg` ← 0 (burst exhausted, BURST→IDLE).
- Register update with no transfer:
  - If `lock_rg`=1 and `i_req_valid[owner_rg]`=0: `lock_rg` ← 0, `cnt_rg` ← 0 (owner released the lock).
  - Otherwise all state holds.
- FIFO full: no transfer and no state advance. A held lock survives a full FIFO as long as the owner stays valid.
- The data path is stateless: a producer's data must be held stable while its valid is high and ready is low.
- `o_locked` = `lock_rg`.

## Timing
- Valid→ready/wren and full→ready/wren are zero-latency combinational paths. Data appears on `o_fifo_wrdata` in the same cycle as the grant.
- The new owner, pointer and lock take effect in the cycle after a transfer.
- Release on owner-valid drop: the register update happens at that clock edge. In the drop cycle itself, the grant already falls back to the round-robin search from `rr_ptr_rg` (= owner+1), so no cycle is wasted.
- Reset values while `rstn`=0, regardless of other inputs:
  - `o_req_ready`=0, `o_fifo_wren`=0, `o_fifo_wrdata`=0, `o_fifo_wrid`=0, `o_locked`=0.
  - `rr_ptr_rg`=0, `owner_rg`=0, `cnt_rg`=0, `lock_rg`=0.
- Reset asserted mid-burst clears the lock. The first grant after reset goes to the lowest-index valid requester.
- Wrap-around: pointer N_REQ-1 advances to 0. The search covers all N_REQ indices, so every valid requester is reachable.
- Fairness: with all requesters continuously valid, each requester receives exactly MAX_BURST consecutive writes per rotation.

## Test plan
- Reset:
  - Stimulus: `rstn`=0 for 3 cycles with all valids=1 and full=0.
  - Response: ready=0, wren=0, locked=0 throughout; first cycle after release grants requester 0 (wrid=0).
- Burst rotation (N_REQ=4, MAX_BURST=4):
  - Stimulus: all valid, full=0, for 16 cycles.
  - Response: wrid sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; wrdata matches each source.
- Pure round-robin (MAX_BURST=1):
  - Stimulus: all valid for 6 cycles.
  - Response: wrid sequence 0,1,2,3,0,1; locked stays 0.
- Backpressure:
  - Stimulus: requester 1 mid-burst with cnt=2; full=1 for 3 cycles, then 0.
  - Response: ready=0 and wren=0 during the 3 full cycles, locked stays 1; after full clears, requester 1 writes twice more, then the grant moves on.
- Owner drop:
  - Stimulus: requester 2 writes 2 words, then drops valid while requesters 0 and 3 stay valid.
  - Response: requester 3 is granted in the same cycle as the drop; requester 0 is granted after requester 3's burst.
- Wrap and sparse requests:
  - Stimulus: only requesters 3 and 0 valid, MAX_BURST=1.
  - Response: wrid alternates 0,3,0,3.
